exu_lsu: RTL

Parametrised, handshaked execute/memory stage for the NPC core. It replaces the single-cycle combinational execute path with a registered stage. It accepts one decoded instruction at a time from decode, performs the load/store bus transaction when one is needed, and presents the result to writeback. Branch/jump redirects and ebreak halts are carried out with that result.

---
 rtl/npc_pkg.sv | 70 +++++++
 rtl/lsu_lane.sv | 46 ++++
 rtl/exu_lsu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/npc_pkg.sv
// Shared NPC definitions: opcode encodings, execute-stage FSM states, access sizes
// and the small opcode classifiers used by the load/store path.
package npc_pkg;

    localparam int OPW = 6;

    // Access size in bytes.
    localparam logic [2:0] BYTE = 3'd1;
    localparam logic [2:0] HALF = 3'd2;
    localparam logic [2:0] WORD = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        WB       = 2'd3
    } state_e;

    localparam logic [OPW-1:0] OP_ADDI   = 6'd0;
    localparam logic [OPW-1:0] OP_ADD    = 6'd1;
    localparam logic [OPW-1:0] OP_SLT    = 6'd2;
    localparam logic [OPW-1:0] OP_SLTI   = 6'd3;
    localparam logic [OPW-1:0] OP_SLTU   = 6'd4;
    localparam logic [OPW-1:0] OP_SLTIU  = 6'd5;
    localparam logic [OPW-1:0] OP_LUI    = 6'd6;
    localparam logic [OPW-1:0] OP_JAL    = 6'd7;
    localparam logic [OPW-1:0] OP_JALR   = 6'd8;
    localparam logic [OPW-1:0] OP_BEQ    = 6'd9;
    localparam logic [OPW-1:0] OP_BNE    = 6'd10;
    localparam logic [OPW-1:0] OP_BLT    = 6'd11;
    localparam logic [OPW-1:0] OP_BGE    = 6'd12;
    localparam logic [OPW-1:0] OP_BLTU   = 6'd13;
    localparam logic [OPW-1:0] OP_BGEU   = 6'd14;
    localparam logic [OPW-1:0] OP_LB     = 6'd15;
    localparam logic [OPW-1:0] OP_LH     = 6'd16;
    localparam logic [OPW-1:0] OP_LW     = 6'd17;
    localparam logic [OPW-1:0] OP_LBU    = 6'd18;
    localparam logic [OPW-1:0] OP_LHU    = 6'd19;
    localparam logic [OPW-1:0] OP_SB     = 6'd20;
    localparam logic [OPW-1:0] OP_SH     = 6'd21;
    localparam logic [OPW-1:0] OP_SW     = 6'd22;
    localparam logic [OPW-1:0] OP_EBREAK = 6'd23;

    function automatic logic is_load(input logic [OPW-1:0] op);
        return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
    endfunction

    function automatic logic is_store(input logic [OPW-1:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic logic is_branch(input logic [OPW-1:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    endfunction

    function automatic logic load_unsigned(input logic [OPW-1:0] op);
        return op inside {OP_LBU, OP_LHU};
    endfunction

    function automatic logic [2:0] mem_size(input logic [OPW-1:0] op);
        logic [2:0] sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = BYTE;
            OP_LH, OP_LHU, OP_SH: sz = HALF;
            default:              sz = WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: load extract/extend, store shift, strobes and
// (with EXU_MISALIGN_TRAP_EN) misalignment detection.
module lsu_lane
    import npc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8,
    parameter int OFFW = $clog2(XLEN / 8)
) (
    input  logic [2:0]      size,
    input  logic            uns,
    input  logic [OFFW-1:0] off,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] wdata,
    output logic [NB-1:0]   wstrb,
`ifdef EXU_MISALIGN_TRAP_EN
    output logic            misalign,
`endif
    output logic [XLEN-1:0] ldata
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] left;
    logic [NB-1:0]   base;
    int unsigned     sh;

    // Extension by pushing the field to the top and shifting back down.
    always_comb begin
        shifted = rdata >> {off, 3'b000};
        case (size)
            BYTE:    begin sh = XLEN - 8;  base = NB'(1);  end
            HALF:    begin sh = XLEN - 16; base = NB'(3);  end
            default: begin sh = XLEN - 32; base = NB'(15); end
        endcase
        left  = shifted << sh;
        ldata = uns ? (left >> sh) : XLEN'($signed(left) >>> sh);
        wdata = rs2_data << {off, 3'b000};
        wstrb = base << off;
    end

`ifdef EXU_MISALIGN_TRAP_EN
    assign misalign = ((size == HALF) && off[0]) || ((size == WORD) && (off[1:0] != 2'b00));
`endif

endmodule

// File: rtl/exu_lsu.sv
// Registered execute/memory stage: accepts one decoded op, runs its bus access if
// any, and holds the result for writeback. EXU_MISALIGN_TRAP_EN adds misalign traps.
module exu_lsu
    import npc_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OPW  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPW-1:0]    option,
    input  logic [XLEN-1:0]   snpc,
    input  logic [XLEN-1:0]   alu_out,
    input  logic [XLEN-1:0]   cmp_out,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   rs2_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [XLEN-1:0]   wb_data,
    output logic              jmp_flag,
    output logic [XLEN-1:0]   jmp_addr,
`ifdef EXU_MISALIGN_TRAP_EN
    output logic              misalign,
`endif
    output logic              halt
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid and its payload hold steady until then and never wait on ready.
    state_e          state_q, state_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d, jmp_addr_q, jmp_addr_d;
    logic [NB-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic            mem_wen_q, mem_wen_d, jmp_flag_q, jmp_flag_d, halt_q, halt_d;
    logic            accept, is_mem;

    logic [2:0]      lane_size;
    logic            lane_uns;
    logic [OFFW-1:0] lane_off;
    logic [XLEN-1:0] lane_wdata, lane_ldata;
    logic [NB-1:0]   lane_wstrb;
`ifdef EXU_MISALIGN_TRAP_EN
    logic            lane_mis, misalign_q, misalign_d;
`endif

    assign accept = in_valid && (state_q == IDLE);
    assign is_mem = is_load(option) || is_store(option);

    // In IDLE the lane sees the incoming op; afterwards the registered access.
    always_comb begin
        if (state_q == IDLE) begin
            lane_size = mem_size(option);
            lane_uns  = load_unsigned(option);
            lane_off  = alu_out[OFFW-1:0];
        end else begin
            lane_size = mem_size(op_q);
            lane_uns  = load_unsigned(op_q);
            lane_off  = mem_addr_q[OFFW-1:0];
        end
    end

    lsu_lane #(.XLEN(XLEN)) u_lane (
        .size     (lane_size),
        .uns      (lane_uns),
        .off      (lane_off),
        .rs2_data (rs2_data),
        .rdata    (mem_rdata),
        .wdata    (lane_wdata),
        .wstrb    (lane_wstrb),
`ifdef EXU_MISALIGN_TRAP_EN
        .misalign (lane_mis),
`endif
        .ldata    (lane_ldata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            mem_wen_q   <= 1'b0;
            wb_data_q   <= '0;
            jmp_flag_q  <= 1'b0;
            jmp_addr_q  <= '0;
            halt_q      <= 1'b0;
`ifdef EXU_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wen_q   <= mem_wen_d;
            wb_data_q   <= wb_data_d;
            jmp_flag_q  <= jmp_flag_d;
            jmp_addr_q  <= jmp_addr_d;
            halt_q      <= halt_d;
`ifdef EXU_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = is_mem ? MEM_REQ : WB;
`ifdef EXU_MISALIGN_TRAP_EN
                    if (is_mem && lane_mis) state_d = WB;
`endif
                end
            end
            MEM_REQ:  if (mem_req_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_rsp_valid) state_d = WB;
            WB:       if (wb_ready)      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wen_d   = mem_wen_q;
        wb_data_d   = wb_data_q;
        jmp_flag_d  = jmp_flag_q;
        jmp_addr_d  = jmp_addr_q;
        halt_d      = halt_q;
`ifdef EXU_MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        if (accept) begin
            op_d       = option;
            wb_data_d  = alu_out;
            jmp_flag_d = 1'b0;
            jmp_addr_d = '0;
            halt_d     = 1'b0;
`ifdef EXU_MISALIGN_TRAP_EN
            misalign_d = is_mem && lane_mis;
`endif
            if (is_mem) begin
                mem_addr_d  = alu_out;
                mem_wen_d   = is_store(option);
                mem_wdata_d = is_store(option) ? lane_wdata : '0;
                mem_wstrb_d = is_store(option) ? lane_wstrb : '0;
                wb_data_d   = '0;
            end else begin
                case (option)
                    OP_JAL, OP_JALR: begin
                        wb_data_d  = snpc;
                        jmp_flag_d = 1'b1;
                        jmp_addr_d = alu_out;
                    end
                    OP_LUI: wb_data_d = imm;
                    OP_SLT, OP_SLTI, OP_SLTU, OP_SLTIU:
                        wb_data_d = (cmp_out == XLEN'(1)) ? XLEN'(1) : '0;
                    OP_EBREAK: halt_d = 1'b1;
                    default: begin
                        if (is_branch(option)) begin
                            wb_data_d  = '0;
                            jmp_flag_d = 1'b1;
                            jmp_addr_d = (cmp_out == XLEN'(1)) ? alu_out : snpc;
                        end
                    end
                endcase
            end
        end else if ((state_q == MEM_WAIT) && mem_rsp_valid && !mem_wen_q) begin
            wb_data_d = lane_ldata;
        end
    end

    always_comb begin
        in_ready      = (state_q == IDLE);
        mem_req_valid = (state_q == MEM_REQ);
        wb_valid      = (state_q == WB);
    end

    assign mem_addr  = mem_addr_q;
    assign mem_wen   = mem_wen_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign wb_data   = wb_data_q;
    assign jmp_flag  = jmp_flag_q;
    assign jmp_addr  = jmp_addr_q;
    assign halt      = halt_q;
`ifdef EXU_MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`endif

endmodule
